// File: rtl/regfile_dump_reader.sv
// Register-file dump engine: walks [cfg_first..cfg_last] through one read port and
// streams each register as low/high beats. Optional REGDUMP_CHECKSUM_EN appends an XOR beat.
module regfile_dump_reader #(
    parameter int DATAPATH_WIDTH = 64,
    parameter int REGFILE_ADDR   = 3,
    parameter int BEAT_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [REGFILE_ADDR-1:0]   cfg_first,
    input  logic [REGFILE_ADDR-1:0]   cfg_last,
    output logic [REGFILE_ADDR-1:0]   raddr,
    input  logic [DATAPATH_WIDTH-1:0] rdata,
    output logic                      freeze,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BEAT_WIDTH-1:0]     out_data,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done
);

    localparam int NUM_BEATS = DATAPATH_WIDTH / BEAT_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_SEND_LO = 3'd2,
        S_SEND_HI = 3'd3,
`ifdef REGDUMP_CHECKSUM_EN
        S_CSUM    = 3'd4,
`endif
        S_DONE    = 3'd5
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic [REGFILE_ADDR-1:0]    r_idx;
    logic [REGFILE_ADDR-1:0]    r_lim;
    logic [REGFILE_ADDR-1:0]    r_raddr;
    logic [DATAPATH_WIDTH-1:0]  r_hold;
    logic                       w_handshake;
    logic                       w_at_lim;
    logic                       w_accept_start;
    logic                       w_empty_range;
    logic [BEAT_WIDTH-1:0]      w_beat [NUM_BEATS];

    // Hold register viewed as an array of beats, beat 0 = least significant word.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BEATS; gi++) begin : g_beat
            assign w_beat[gi] = r_hold[gi*BEAT_WIDTH +: BEAT_WIDTH];
        end
    endgenerate

    assign w_handshake    = out_valid && out_ready;
    assign w_at_lim       = (r_idx == r_lim);
    assign w_accept_start = (r_state == S_IDLE) && start;
    assign w_empty_range  = (cfg_first > cfg_last);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_empty_range) begin
`ifdef REGDUMP_CHECKSUM_EN
                        w_state_next = S_CSUM;
`else
                        w_state_next = S_DONE;
`endif
                    end else begin
                        w_state_next = S_READ;
                    end
                end
            end
            S_READ: begin
                w_state_next = S_SEND_LO;
            end
            S_SEND_LO: begin
                if (w_handshake) begin
                    w_state_next = S_SEND_HI;
                end
            end
            S_SEND_HI: begin
                if (w_handshake) begin
                    if (w_at_lim) begin
`ifdef REGDUMP_CHECKSUM_EN
                        w_state_next = S_CSUM;
`else
                        w_state_next = S_DONE;
`endif
                    end else begin
                        w_state_next = S_READ;
                    end
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            S_CSUM: begin
                if (w_handshake) begin
                    w_state_next = S_DONE;
                end
            end
`endif
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

`ifdef REGDUMP_CHECKSUM_EN
    logic [BEAT_WIDTH-1:0] r_csum;

    // Running XOR of every accepted data beat of the current dump.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_csum <= '0;
        end else if (w_accept_start) begin
            r_csum <= '0;
        end else if (w_handshake && ((r_state == S_SEND_LO) || (r_state == S_SEND_HI))) begin
            r_csum <= r_csum ^ out_data;
        end
    end
`endif

    // Output logic; everything decodes from registered state so reset clears it at once.
    always_comb begin
        raddr     = r_raddr;
        busy      = (r_state != S_IDLE);
        freeze    = (r_state != S_IDLE);
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        done      = 1'b0;
        case (r_state)
            S_READ: begin
                raddr = r_idx;
            end
            S_SEND_LO: begin
                out_valid = 1'b1;
                out_data  = w_beat[0];
            end
            S_SEND_HI: begin
                out_valid = 1'b1;
                out_data  = w_beat[1];
`ifndef REGDUMP_CHECKSUM_EN
                out_last  = w_at_lim;
`endif
            end
`ifdef REGDUMP_CHECKSUM_EN
            S_CSUM: begin
                out_valid = 1'b1;
                out_data  = r_csum;
                out_last  = 1'b1;
            end
`endif
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Index/limit, snapshot and the read address that persists outside READ.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx   <= '0;
            r_lim   <= '0;
            r_raddr <= '0;
            r_hold  <= '0;
        end else begin
            if (w_accept_start) begin
                r_idx <= cfg_first;
                r_lim <= cfg_last;
            end
            if (r_state == S_READ) begin
                r_hold  <= rdata;
                r_raddr <= r_idx;
            end
            // Never steps past the limit, so a range ending at the top index cannot wrap.
            if ((r_state == S_SEND_HI) && w_handshake && !w_at_lim) begin
                r_idx <= r_idx + REGFILE_ADDR'(1);
            end
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: table of dump ranges/ready patterns checked against a beat scoreboard.
module tb_regfile_dump_reader;

    localparam int AW = 3;
    localparam int DW = 64;
    localparam int BW = 32;
`ifdef REGDUMP_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] cfg_first = '0;
    logic [AW-1:0] cfg_last = '0;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic          freeze;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [BW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] regs [8];
    assign rdata = regs[raddr];

    regfile_dump_reader #(.DATAPATH_WIDTH(DW), .REGFILE_ADDR(AW), .BEAT_WIDTH(BW)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_first(cfg_first), .cfg_last(cfg_last),
        .raddr(raddr), .rdata(rdata), .freeze(freeze), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [BW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        int first;
        int last;
        int mode;    // 0: ready always high, 1: ready pattern 1-0-0-1
        int regsel;  // 0: spec r2/r3, 1: i*0101.., 2: random
    } vec_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    failures = 0;
    int    ready_mode = 0;
    beat_t mon_e;
    logic          prev_stall = 1'b0;
    logic [BW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic load_regs(input int sel);
        for (int i = 0; i < 8; i++) begin
            if (sel == 2) regs[i] = {$urandom, $urandom};
            else          regs[i] = 64'(i) * 64'h0101_0101_0101_0101;
        end
        if (sel == 0) begin
            regs[2] = 64'h1111_2222_3333_4444;
            regs[3] = 64'hAAAA_BBBB_CCCC_DDDD;
        end
    endtask

    // Ready driver: changes just after each rising edge.
    initial begin
        int ph = 0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = (ready_mode == 0) ? 1'b1 : ((ph == 0) || (ph == 3));
            ph = (ph + 1) % 4;
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks stall stability.
    always @(negedge clk) begin
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_data", 64'(out_data), 64'(prev_data));
                chk("stall_last", 64'(out_last), 64'(prev_last));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=%h required=none", out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    $display("beat data=%h last=%b", out_data, out_last);
                    chk("beat_data", 64'(out_data), 64'(mon_e.data));
                    chk("beat_last", 64'(out_last), 64'(mon_e.last));
                    chk("beat_freeze", 64'(freeze), 64'd1);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    task automatic run_dump(input int first, input int last, input int mode);
        int n;
        int k;
        int exp_done;
        bit got;
        logic [BW-1:0] cs;
        ready_mode = mode;
        @(posedge clk);
        #1;
        start = 1'b1;
        cfg_first = AW'(first);
        cfg_last = AW'(last);
        n = (first > last) ? 0 : (last - first + 1);
        cs = '0;
        for (int i = first; i <= last; i++) begin
            exp_q.push_back({regs[i][31:0], 1'b0});
            exp_q.push_back({regs[i][63:32], (i == last) && !CSUM});
            cs = cs ^ regs[i][31:0] ^ regs[i][63:32];
        end
        if (CSUM) exp_q.push_back({cs, 1'b1});
        exp_done = ((n == 0) ? 1 : (3 * n + 1)) + (CSUM ? 1 : 0);
        k = 0;
        got = 1'b0;
        while (k < 300 && !got) begin
            @(posedge clk);
            k++;
            if (k == 1) begin
                #1;
                start = 1'b0;
            end
            @(negedge clk);
            if (k == 1) begin
                chk("valid_t1", 64'(out_valid), 64'(CSUM && n == 0));
                chk("busy_t1", 64'(busy), 64'd1);
                chk("freeze_t1", 64'(freeze), 64'd1);
            end
            if (k == 2 && n > 0) chk("valid_t2", 64'(out_valid), 64'd1);
            if (done) got = 1'b1;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=none required=done");
        end
        if (mode == 0) chk("done_cycle", 64'(k), 64'(exp_done));
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_freeze", 64'(freeze), 64'd0);
        $display("dump first=%0d last=%0d mode=%0d regs=%0d cycles=%0d", first, last, mode, n, k);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_data"}, 64'(out_data), 64'd0);
        chk({tag, "_last"}, 64'(out_last), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_freeze"}, 64'(freeze), 64'd0);
        chk({tag, "_raddr"}, 64'(raddr), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[7];
        int k;
        vt[0] = '{2, 3, 0, 0};
        vt[1] = '{0, 7, 0, 1};
        vt[2] = '{0, 7, 1, 1};
        vt[3] = '{5, 4, 0, 1};
        vt[4] = '{7, 7, 1, 2};
        vt[5] = '{3, 6, 1, 2};
        vt[6] = '{0, 0, 0, 2};

        load_regs(0);
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk);
        #1;
        reset = 1'b1;

        for (int t = 0; t < 7; t++) begin
            load_regs(vt[t].regsel);
            run_dump(vt[t].first, vt[t].last, vt[t].mode);
        end

        // Abort during the high beat of register 1, then dump again.
        load_regs(1);
        ready_mode = 0;
        @(posedge clk);
        #1;
        start = 1'b1;
        cfg_first = 3'd0;
        cfg_last = 3'd3;
        for (int i = 0; i <= 3; i++) begin
            exp_q.push_back({regs[i][31:0], 1'b0});
            exp_q.push_back({regs[i][63:32], 1'b0});
        end
        k = 0;
        while (k < 6) begin
            @(posedge clk);
            k++;
            if (k == 1) begin
                #1;
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk("abort_at_hi_data", 64'(out_data), 64'(regs[1][63:32]));
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("abort");
        exp_q.delete();
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", 64'(done), 64'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        load_regs(0);
        run_dump(2, 3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
